// File: rtl/mips_cpu_fetch_unit_if.sv
// Fetch unit bus bundle: Avalon-style instruction read port, the fetched
// instruction presented to decode, and the controller's retire/branch inputs.
//   master : the fetch unit (drives mem_address/mem_read, instr_*, active)
//   slave  : memory + controller side (drives waitrequest/readdata, fetch_next,
//            branch_req/branch_target)
interface mips_cpu_fetch_unit_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        fetch_next;
  logic        branch_req;
  logic [31:0] branch_target;
  logic        active;

  modport master (
    output mem_address, mem_read, instr_word, instr_pc, instr_valid, active,
    input  mem_waitrequest, mem_readdata, fetch_next, branch_req, branch_target
  );

  modport slave (
    input  mem_address, mem_read, instr_word, instr_pc, instr_valid, active,
    output mem_waitrequest, mem_readdata, fetch_next, branch_req, branch_target
  );
endinterface

// File: rtl/mips_cpu_fetch_unit.sv
// Instruction fetch stage of the multicycle MIPS CPU.
// Owns the PC, reads one word per instruction over the Avalon-style bus
// (stalling on waitrequest), holds the word plus its PC for decode, and
// applies branch/jump targets after one delay slot. A taken target of 0
// halts the CPU until reset.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mips_cpu_fetch_unit_if.master (memory read port, instr_* outputs,
//           fetch_next / branch_req / branch_target, active)
module mips_cpu_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_cpu_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state_q;
  logic [31:0] pc_q, tgt_q, instr_word_q, instr_pc_q;
  logic        pend_q, slot_q;
  logic        mem_read_q, instr_valid_q, active_q;

  // Branch bookkeeping with this cycle's branch_req folded in. A branch_req
  // seen while one is already pending sits in a delay slot and is dropped.
  logic        pend_e, slot_e;
  logic [31:0] tgt_e;

  always_comb begin
    pend_e = pend_q;
    slot_e = slot_q;
    tgt_e  = tgt_q;
    if (bus.branch_req && !pend_q) begin
      pend_e = 1'b1;
      slot_e = 1'b0;
      tgt_e  = {bus.branch_target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      tgt_q         <= '0;
      pend_q        <= 1'b0;
      slot_q        <= 1'b0;
      instr_word_q  <= '0;
      instr_pc_q    <= '0;
      mem_read_q    <= 1'b1;
      instr_valid_q <= 1'b0;
      active_q      <= 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          if (!bus.mem_waitrequest) begin
            instr_word_q  <= bus.mem_readdata;
            instr_pc_q    <= pc_q;
            state_q       <= HOLD;
            mem_read_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          pend_q <= pend_e;
          slot_q <= slot_e;
          tgt_q  <= tgt_e;
          if (bus.fetch_next) begin
            instr_valid_q <= 1'b0;
            if (pend_e && slot_e) begin
              // delay slot retiring: take the target
              pc_q   <= tgt_e;
              pend_q <= 1'b0;
              slot_q <= 1'b0;
              if (tgt_e == '0) begin
                state_q  <= HALTED;
                active_q <= 1'b0;
              end else begin
                state_q    <= FETCH;
                mem_read_q <= 1'b1;
              end
            end else begin
              // sequential; if a branch is pending the next fetch is its slot
              pc_q       <= pc_q + 32'd4;
              slot_q     <= pend_e;
              state_q    <= FETCH;
              mem_read_q <= 1'b1;
            end
          end
        end
        default: ; // HALTED: only reset leaves
      endcase
    end
  end

  // Reset held low must not present a read even though state is FETCH.
  assign bus.mem_read    = mem_read_q & rst_n;
  assign bus.mem_address = pc_q;
  assign bus.instr_word  = instr_word_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_mips_cpu_fetch_unit.sv
// Bench for mips_cpu_fetch_unit: directed scenarios plus randomized
// instruction streams, all checked against an instruction-level model of
// the PC / delay-slot rules.
module tb_mips_cpu_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_cpu_fetch_unit_if bus();

  mips_cpu_fetch_unit #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errs    = 0;

  // instruction-level reference model
  logic [31:0] m_pc, m_tgt;
  bit          m_pend, m_slot, m_halt;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_0005;
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_3C3C;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_next      = 1'b0;
    bus.branch_req      = 1'b0;
    bus.branch_target   = '0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata    = '0;
  endtask

  task automatic model_reset();
    m_pc = 32'hBFC0_0000; m_tgt = '0; m_pend = 0; m_slot = 0; m_halt = 0;
  endtask

  task automatic model_branch(input logic [31:0] t);
    if (!m_pend) begin
      m_pend = 1; m_slot = 0; m_tgt = {t[31:2], 2'b00};
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    cyc(); cyc();
    vectors++;
    if (bus.mem_read !== 1'b0) begin
      errs++; $display("FAIL rst_hold_mem_read got=%b exp=0", bus.mem_read);
    end
    rst_n = 1'b1;
    #1;
    model_reset();
  endtask

  // One full instruction: fetch with `waits` stall cycles, `idles` HOLD
  // cycles (branch on the first if br_idle), then a retiring fetch_next
  // (with a simultaneous branch if br_retire).
  task automatic run_instr(input int waits, input int idles, input bit br_idle,
                           input logic [31:0] tgt, input bit br_retire,
                           input logic [31:0] tgt2);
    logic [31:0] fpc;
    fpc = m_pc;
    vectors++;
    if (bus.mem_read !== 1'b1 || bus.mem_address !== fpc || bus.instr_valid !== 1'b0
        || bus.active !== 1'b1) begin
      errs++; $display("FAIL fetch_entry rd=%b addr=%h iv=%b act=%b exp rd=1 addr=%h iv=0 act=1",
                       bus.mem_read, bus.mem_address, bus.instr_valid, bus.active, fpc);
    end
    for (int w = 0; w < waits; w++) begin
      bus.mem_waitrequest = 1'b1;
      bus.mem_readdata    = $urandom;
      bus.fetch_next      = 1'($urandom_range(0, 1));
      bus.branch_req      = 1'($urandom_range(0, 1));
      bus.branch_target   = $urandom;
      cyc();
      vectors++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== fpc || bus.instr_valid !== 1'b0) begin
        errs++; $display("FAIL stall rd=%b addr=%h iv=%b exp rd=1 addr=%h iv=0",
                         bus.mem_read, bus.mem_address, bus.instr_valid, fpc);
      end
    end
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata    = mem_fn(fpc);
    bus.fetch_next      = 1'($urandom_range(0, 1));
    bus.branch_req      = 1'($urandom_range(0, 1));
    bus.branch_target   = $urandom;
    cyc();
    bus.mem_readdata    = $urandom;
    bus.mem_waitrequest = 1'($urandom_range(0, 1));
    vectors++;
    if (bus.instr_valid !== 1'b1 || bus.mem_read !== 1'b0 || bus.instr_word !== mem_fn(fpc)
        || bus.instr_pc !== fpc) begin
      errs++; $display("FAIL hold iv=%b rd=%b word=%h pc=%h exp iv=1 rd=0 word=%h pc=%h",
                       bus.instr_valid, bus.mem_read, bus.instr_word, bus.instr_pc,
                       mem_fn(fpc), fpc);
    end
    for (int i = 0; i < idles; i++) begin
      bus.fetch_next    = 1'b0;
      bus.branch_req    = (i == 0) && br_idle;
      bus.branch_target = tgt;
      if (bus.branch_req) model_branch(tgt);
      cyc();
      vectors++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== fpc || bus.mem_read !== 1'b0) begin
        errs++; $display("FAIL hold_idle iv=%b pc=%h rd=%b exp iv=1 pc=%h rd=0",
                         bus.instr_valid, bus.instr_pc, bus.mem_read, fpc);
      end
    end
    bus.fetch_next    = 1'b1;
    bus.branch_req    = br_retire;
    bus.branch_target = tgt2;
    if (br_retire) model_branch(tgt2);
    if (m_pend && m_slot) begin
      m_pc = m_tgt; m_pend = 0; m_slot = 0;
      if (m_tgt == '0) m_halt = 1;
    end else begin
      m_pc = m_pc + 32'd4;
      if (m_pend) m_slot = 1;
    end
    cyc();
    idle_inputs();
    if (m_halt) begin
      vectors++;
      if (bus.active !== 1'b0 || bus.mem_read !== 1'b0 || bus.instr_valid !== 1'b0
          || bus.mem_address !== 32'h0 || bus.instr_pc !== fpc) begin
        errs++; $display("FAIL halt_entry act=%b rd=%b iv=%b addr=%h ipc=%h exp 0 0 0 0 %h",
                         bus.active, bus.mem_read, bus.instr_valid, bus.mem_address,
                         bus.instr_pc, fpc);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'hBFC0_0000 || bus.instr_valid !== 1'b0
        || bus.active !== 1'b1 || bus.instr_word !== 32'h0 || bus.instr_pc !== 32'h0) begin
      errs++; $display("FAIL reset_state rd=%b addr=%h iv=%b act=%b w=%h pc=%h",
                       bus.mem_read, bus.mem_address, bus.instr_valid, bus.active,
                       bus.instr_word, bus.instr_pc);
    end
  endtask

  task automatic test_first_fetch();
    do_reset();
    run_instr(0, 1, 0, 32'h0, 0, 32'h0);   // word 2402_0005 checked in HOLD
  endtask

  task automatic test_wait();
    do_reset();
    run_instr(3, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_sequential_branch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.mem_address !== 32'hBFC0_0000 + 32'(4 * i)) begin
        errs++; $display("FAIL seq_addr%0d got=%h exp=%h", i, bus.mem_address,
                         32'hBFC0_0000 + 32'(4 * i));
      end
      run_instr(i % 2, i % 3, 0, 32'h0, 0, 32'h0);
    end
    run_instr(0, 0, 0, 32'h0, 1, 32'hBFC0_0101);
    vectors++;
    if (bus.mem_address !== 32'hBFC0_0014) begin
      errs++; $display("FAIL delay_slot_addr got=%h exp=bfc00014", bus.mem_address);
    end
    run_instr(1, 1, 1, 32'h1234_5678, 0, 32'h0);  // branch in slot: dropped
    vectors++;
    if (bus.mem_address !== 32'hBFC0_0100) begin
      errs++; $display("FAIL branch_tgt_addr got=%h exp=bfc00100", bus.mem_address);
    end
    run_instr(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(0, 2, 1, 32'hFFFF_FFFF, 0, 32'h0);
    run_instr(0, 0, 0, 32'h0, 0, 32'h0);
    run_instr(0, 0, 0, 32'h0, 0, 32'h0);          // at FFFF_FFFC
    vectors++;
    if (bus.mem_address !== 32'h0 || bus.active !== 1'b1 || bus.mem_read !== 1'b1) begin
      errs++; $display("FAIL wrap addr=%h act=%b rd=%b exp 0 1 1", bus.mem_address,
                       bus.active, bus.mem_read);
    end
    run_instr(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  task automatic test_halt();
    do_reset();
    run_instr(1, 1, 1, 32'h0000_0003, 0, 32'h0);  // target masks to 0
    run_instr(0, 0, 0, 32'h0, 1, 32'h0000_0100);  // delay slot retires
    for (int c = 0; c < 20; c++) begin
      bus.fetch_next      = 1'($urandom_range(0, 1));
      bus.branch_req      = 1'($urandom_range(0, 1));
      bus.branch_target   = $urandom;
      bus.mem_waitrequest = 1'($urandom_range(0, 1));
      cyc();
      vectors++;
      if (bus.active !== 1'b0 || bus.mem_read !== 1'b0 || bus.instr_valid !== 1'b0
          || bus.mem_address !== 32'h0) begin
        errs++; $display("FAIL halted c%0d act=%b rd=%b iv=%b addr=%h exp 0 0 0 0", c,
                         bus.active, bus.mem_read, bus.instr_valid, bus.mem_address);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midstall();
    do_reset();
    run_instr(0, 0, 0, 32'h0, 1, 32'hBFC0_4000);  // pend set, slot next
    bus.mem_waitrequest = 1'b1;
    cyc();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_read !== 1'b0) begin
      errs++; $display("FAIL rst_midstall_rd got=%b exp=0", bus.mem_read);
    end
    cyc();
    vectors++;
    if (bus.mem_read !== 1'b0) begin
      errs++; $display("FAIL rst_low_rd got=%b exp=0", bus.mem_read);
    end
    bus.mem_waitrequest = 1'b0;
    rst_n = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.mem_address !== 32'hBFC0_0000 + 32'(4 * i)) begin
        errs++; $display("FAIL post_rst_addr%0d got=%h exp=%h", i, bus.mem_address,
                         32'hBFC0_0000 + 32'(4 * i));
      end
      run_instr(0, 0, 0, 32'h0, 0, 32'h0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                $urandom | 32'h10, ($urandom_range(0, 3) == 0), $urandom | 32'h20);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_wait();
    test_sequential_branch();
    test_wrap();
    test_halt();
    test_reset_midstall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mips_cpu_fetch_unit.md
# mips_cpu_fetch_unit

Instruction fetch stage of the multicycle MIPS CPU. Owns the program counter and issues word reads on the Avalon-style memory bus, stalling on `mem_waitrequest`. Presents each fetched word to the instruction register and decode logic together with its PC. Applies branch and jump targets with one MIPS delay slot, and halts the CPU when control transfers to address 0.

## Interface
- `RESET_VECTOR`, default 32'hBFC0_0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `mem_address`  out  32: byte address of the fetch; always equals current PC.
- `mem_read`  out  1: read request; high only in FETCH.
- `mem_waitrequest`  in  1: bus stall; the read is accepted on a cycle with `mem_read`=1 and `mem_waitrequest`=0.
- `mem_readdata`  in  32: read data, valid in the accepting cycle.
- `instr_word`  out  32: registered fetched instruction.
- `instr_pc`  out  32: address `instr_word` was fetched from.
- `instr_valid`  out  1: high while in HOLD.
- `fetch_next`  in  1: controller pulse; the current instruction is retired, so fetch the next one.
- `branch_req`  in  1: the instruction in HOLD redirects control flow.
- `branch_target`  in  32: target address, sampled with `branch_req`.
- `active`  out  1: high until the halt condition.

## Operation
- State machine states: FETCH, HOLD, HALTED.
- FETCH:
  - `mem_read`=1 and `mem_address`=pc.
  - On acceptance (`mem_waitrequest`=0), register `instr_word`←`mem_readdata` and `instr_pc`←pc, then go to HOLD.
  - While `mem_waitrequest`=1, stay in FETCH and hold address and read stable.
  - `fetch_next` and `branch_req` are ignored in FETCH.
- HOLD:
  - `mem_read`=0 and `instr_valid`=1.
  - `instr_word` and `instr_pc` are stable until the next acceptance.
  - `branch_req`=1 while `pend`=0: store `tgt`←{`branch_target`[31:2],2'b00} and set `pend`=1, `slot`=0.
  - `branch_req`=1 while `pend`=1 (branch in a delay slot) is ignored.
- `fetch_next` in HOLD returns the FSM to FETCH on the next cycle, with the PC update below.
  - If `pend`=0, or `pend`=1 with `slot`=0: pc←pc+4, modulo 2^32 so 32'hFFFF_FFFC wraps to 0. If `pend`=1, also set `slot`←1, because the next fetch is the delay slot.
  - If `pend`=1 with `slot`=1, the delay slot is retiring: pc←`tgt` and clear `pend` and `slot`. If `tgt`==0, go to HALTED instead of FETCH.
- Simultaneous `branch_req` and `fetch_next` in HOLD: the branch is recorded first, then the `fetch_next` rule runs with `pend`=1, `slot`=0. Result: pc←pc+4 and `slot`←1. This is the normal single-cycle branch retire.
- HALTED:
  - `active`=0, `mem_read`=0, `instr_valid`=0.
  - All inputs are ignored; the FSM leaves HALTED only through reset.
  - `mem_address` holds 0; `instr_word` and `instr_pc` hold the delay-slot values.
- Sequential fall-through to address 0 by wrap-around does not halt. Only a taken target of 0 halts.

## Timing
- Reset (`rst_n`=0 at an edge) gives, in the next cycle:
  - pc=`RESET_VECTOR`, state FETCH, `instr_word`=0, `instr_pc`=0, `instr_valid`=0, `active`=1, `pend`=0, `slot`=0.
  - While `rst_n` is held low, `mem_read`=0.
- Reset mid-fetch (`mem_read` high, waitrequest pending) abandons the request. The bus may drop `mem_read` without completion.
- Fetch latency: `instr_valid` rises one cycle after the accepting cycle. With zero wait states: 1 cycle in FETCH, then `instr_valid` on cycle 2.
- `fetch_next` to the next `mem_read`: exactly 1 cycle.
- Minimum instruction period: 2 cycles (FETCH accept + HOLD with `fetch_next`).
- `active` falls one cycle after the `fetch_next` that retires the delay slot of a jump to 0.

## Test plan
- Reset, zero-wait bus returning 32'h2402_0005 → `mem_address`=32'hBFC0_0000 and `mem_read`=1 on cycle 1. On cycle 2, `instr_valid`=1, `instr_word`=32'h2402_0005, `instr_pc`=32'hBFC0_0000.
- `mem_waitrequest` high for 3 cycles → `mem_read` and `mem_address` stay stable for 4 cycles. `instr_valid` rises exactly one cycle after waitrequest falls.
- Sequential: 3 `fetch_next` pulses → fetch addresses BFC00000, BFC00004, BFC00008, BFC0000C in order.
- `branch_req` with target 32'hBFC0_0101 and `fetch_next` in the same cycle at pc BFC00010 → next fetch is BFC00014 (delay slot). After the next `fetch_next`, the fetch is BFC00100 (low bits dropped).
- Jump to 0 → the delay slot is fetched. After its `fetch_next`, `active`=0 and `mem_read` stays 0 for 20 cycles despite `fetch_next`/`branch_req` stimulus.
- `rst_n` low during a waitrequest stall → `mem_read`=0 while in reset. After release, fetch restarts at BFC00000 with `pend` cleared.
